// File: rtl/alu_op_responder_if.sv
// ============================================================================
// Module  : alu_op_responder_if
// Brief   : ALU start/done operation handshake bundle (operands, opcode, result).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_op_responder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2:0]         op;
  logic               start;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               illegal;
  logic               busy;

  modport master (
    output A, B, op, start,
    input  done, result, illegal, busy
  );

  modport slave (
    input  A, B, op, start,
    output done, result, illegal, busy
  );
endinterface

`default_nettype wire

// File: rtl/alu_op_responder.sv
// ============================================================================
// Module  : alu_op_responder
// Brief   : Responder end of the ALU start/done handshake; optional saturating
//           completion counter enabled by macro ALU_RESP_OP_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_responder #(
  parameter int WIDTH       = 8,
  parameter int MUL_LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  alu_op_responder_if.slave bus
`ifdef ALU_RESP_OP_COUNT_EN
  ,
  output logic [15:0]       op_count
`endif
);

  localparam int RW = 2 * WIDTH;

  localparam logic [2:0] c_op_nop = 3'd0;
  localparam logic [2:0] c_op_add = 3'd1;
  localparam logic [2:0] c_op_and = 3'd2;
  localparam logic [2:0] c_op_xor = 3'd3;
  localparam logic [2:0] c_op_mul = 3'd4;
  localparam logic [2:0] c_op_rst = 3'd7;

  localparam logic [2:0] c_mul_last = 3'(MUL_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    MUL_BUSY     = 2'd1,
    DONE         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [RW-1:0]    r_result;
  logic             r_done;
  logic             r_illegal;
  logic             r_busy;

  logic             w_start_op;
  logic             w_finish;
  logic             w_is_illegal;
  logic [2:0]       w_last;
  logic [RW-1:0]    w_a_ext;
  logic [RW-1:0]    w_b_ext;
  logic [RW-1:0]    w_result;

  // Single-cycle ops make one pass through the busy state; only mul stretches it.
  assign w_start_op   = (r_state == IDLE) && bus.start;
  assign w_last       = (r_op == c_op_mul) ? c_mul_last : 3'd0;
  assign w_finish     = (r_state == MUL_BUSY) && (r_cnt == w_last);
  assign w_is_illegal = (r_op == 3'd5) || (r_op == 3'd6);
  assign w_a_ext      = RW'(r_a);
  assign w_b_ext      = RW'(r_b);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next_state = MUL_BUSY;
      end
      MUL_BUSY: begin
        if (w_finish) w_next_state = DONE;
      end
      DONE: begin
        w_next_state = bus.start ? WAIT_RELEASE : IDLE;
      end
      WAIT_RELEASE: begin
        if (!bus.start) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_result = r_result;
    case (r_op)
      c_op_nop: w_result = r_result;
      c_op_add: w_result = w_a_ext + w_b_ext;
      c_op_and: w_result = w_a_ext & w_b_ext;
      c_op_xor: w_result = w_a_ext ^ w_b_ext;
      c_op_mul: w_result = w_a_ext * w_b_ext;
      c_op_rst: w_result = '0;
      default:  w_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= 3'd0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= 3'd0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done    <= w_finish;
      r_illegal <= w_finish && w_is_illegal;
      r_busy    <= (w_next_state == MUL_BUSY);
      if (w_start_op) begin
        r_a   <= bus.A;
        r_b   <= bus.B;
        r_op  <= bus.op;
        r_cnt <= 3'd0;
      end else if ((r_state == MUL_BUSY) && !w_finish) begin
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_finish) begin
        r_result <= w_result;
      end
    end
  end

  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign bus.illegal = r_illegal;
  assign bus.busy    = r_busy;

`ifdef ALU_RESP_OP_COUNT_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_count <= 16'd0;
    end else if (w_finish && (r_op_count != 16'hFFFF)) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign op_count = r_op_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_op_responder.sv
// ============================================================================
// Module  : tb_alu_op_responder
// Brief   : Self-checking bench for alu_op_responder with a result/latency model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_responder;

  localparam int WIDTH       = 8;
  localparam int MUL_LATENCY = 3;

  logic clk;
  logic reset;
  int   checks;
  int   fails;
  logic [15:0] prev_result;
  int   model_count;

  alu_op_responder_if #(.WIDTH(WIDTH)) bus ();

`ifdef ALU_RESP_OP_COUNT_EN
  logic [15:0] op_count;
`endif

  alu_op_responder #(
    .WIDTH      (WIDTH),
    .MUL_LATENCY(MUL_LATENCY)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef ALU_RESP_OP_COUNT_EN
    ,
    .op_count(op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_result(input int o, input int a, input int b,
                                               input logic [15:0] prev);
    case (o)
      0:       return prev;
      1:       return 16'(a + b);
      2:       return 16'(a & b);
      3:       return 16'(a ^ b);
      4:       return 16'(a * b);
      default: return 16'd0;
    endcase
  endfunction

  // Holds start for `window` edges, scrambling operands after the sample edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                        input int window, output int lat, output int ndone, output int nbusy,
                        output logic [15:0] res, output int nill);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.op = o; bus.start = 1'b1;
    lat = -1; ndone = 0; nbusy = 0; nill = 0; res = 16'hDEAD;
    for (int e = 0; e < window; e++) begin
      @(posedge clk); #1;
      if (bus.busy === 1'b1) nbusy++;
      if (bus.done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = e;
        res = bus.result;
      end
      if (bus.illegal === 1'b1) nill++;
      if (e == 0) begin
        bus.A = 8'($urandom); bus.B = 8'($urandom); bus.op = 3'($urandom);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    if (bus.done === 1'b1) ndone++;
    if (lat >= 0) model_count++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.A = '0; bus.B = '0; bus.op = '0; bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.done, bus.illegal, bus.busy, bus.result} !== 19'd0) begin
      fails++;
      $display("FAIL reset_state: got done=%b illegal=%b busy=%b result=%h, want all 0",
               bus.done, bus.illegal, bus.busy, bus.result);
    end
    @(negedge clk);
    reset = 1'b0;
    prev_result = 16'd0;
    model_count = 0;
  endtask

  task automatic test_mul_hold();
    int lat, nd, nb, ni;
    logic [15:0] res;
    run_op(8'd3, 8'd5, 3'd4, 8, lat, nd, nb, res, ni);
    checks++;
    if (lat !== MUL_LATENCY || nd !== 1) begin
      fails++;
      $display("FAIL mul_latency: got lat=%0d pulses=%0d, want lat=%0d pulses=1", lat, nd, MUL_LATENCY);
    end
    checks++;
    if (res !== 16'd15 || nb !== MUL_LATENCY || ni !== 0) begin
      fails++;
      $display("FAIL mul_result: got res=%0d busy_edges=%0d illegal=%0d, want 15/%0d/0", res, nb, MUL_LATENCY, ni);
    end
    prev_result = 16'd15;
  endtask

  task automatic test_single_ops();
    int lat, nd, nb, ni;
    logic [15:0] res;
    run_op(8'd255, 8'd255, 3'd1, 6, lat, nd, nb, res, ni);
    checks++;
    if (lat !== 1 || res !== 16'd510 || nb !== 1) begin
      fails++;
      $display("FAIL add_full_scale: got lat=%0d res=%0d busy=%0d, want 1/510/1", lat, res, nb);
    end
    run_op(8'hF0, 8'h3C, 3'd2, 6, lat, nd, nb, res, ni);
    checks++;
    if (lat !== 1 || res !== 16'h0030) begin
      fails++;
      $display("FAIL and_op: got lat=%0d res=%h, want 1/0030", lat, res);
    end
    run_op(8'hF0, 8'h3C, 3'd3, 6, lat, nd, nb, res, ni);
    checks++;
    if (lat !== 1 || res !== 16'h00CC) begin
      fails++;
      $display("FAIL xor_op: got lat=%0d res=%h, want 1/00cc", lat, res);
    end
    run_op(8'h11, 8'h22, 3'd0, 6, lat, nd, nb, res, ni);
    checks++;
    if (lat !== 1 || res !== 16'h00CC) begin
      fails++;
      $display("FAIL no_op_hold: got lat=%0d res=%h, want 1/00cc", lat, res);
    end
    prev_result = 16'h00CC;
  endtask

  task automatic test_held_start();
    int lat, nd, nb, ni;
    logic [15:0] res;
    run_op(8'd7, 8'd8, 3'd1, 10, lat, nd, nb, res, ni);
    checks++;
    if (nd !== 1 || res !== 16'd15) begin
      fails++;
      $display("FAIL held_start_once: got pulses=%0d res=%0d, want 1/15", nd, res);
    end
    run_op(8'd9, 8'd8, 3'd1, 10, lat, nd, nb, res, ni);
    checks++;
    if (nd !== 1 || res !== 16'd17) begin
      fails++;
      $display("FAIL held_start_rearm: got pulses=%0d res=%0d, want 1/17", nd, res);
    end
    prev_result = 16'd17;
  endtask

  task automatic test_illegal();
    int lat, nd, nb, ni;
    logic [15:0] res;
    run_op(8'd9, 8'd9, 3'd5, 6, lat, nd, nb, res, ni);
    checks++;
    if (lat !== 1 || nd !== 1 || ni !== 1 || res !== 16'd0) begin
      fails++;
      $display("FAIL illegal_op: got lat=%0d done=%0d illegal=%0d res=%0d, want 1/1/1/0", lat, nd, ni, res);
    end
    run_op(8'd1, 8'd1, 3'd1, 6, lat, nd, nb, res, ni);
    checks++;
    if (res !== 16'd2 || ni !== 0) begin
      fails++;
      $display("FAIL after_illegal: got res=%0d illegal=%0d, want 2/0", res, ni);
    end
    prev_result = 16'd2;
  endtask

  task automatic test_reset_mid_mul();
    int lat, nd, nb, ni, seen;
    logic [15:0] res;
    run_op(8'd3, 8'd5, 3'd4, 6, lat, nd, nb, res, ni);
    checks++;
    if (res !== 16'd15) begin
      fails++;
      $display("FAIL pre_reset_mul: got res=%0d, want 15", res);
    end
    @(negedge clk);
    bus.A = 8'd4; bus.B = 8'd6; bus.op = 3'd4; bus.start = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen++;
    end
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0 || bus.result !== 16'd0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_mul: got pulses=%0d res=%0d busy=%b, want 0/0/0", seen, bus.result, bus.busy);
    end
    model_count = 0;
    run_op(8'd3, 8'd5, 3'd4, 6, lat, nd, nb, res, ni);
    run_op(8'd3, 8'd5, 3'd7, 6, lat, nd, nb, res, ni);
    checks++;
    if (nd !== 1 || res !== 16'd0) begin
      fails++;
      $display("FAIL rst_op: got pulses=%0d res=%0d, want 1/0", nd, res);
    end
    prev_result = 16'd0;
  endtask

  task automatic test_random();
    int lat, nd, nb, ni, exp_lat;
    logic [15:0] res, exp_res;
    logic [7:0] a, b;
    logic [2:0] o;
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom); b = 8'($urandom); o = 3'($urandom);
      exp_res = model_result(int'(o), int'(a), int'(b), prev_result);
      exp_lat = (o == 3'd4) ? MUL_LATENCY : 1;
      run_op(a, b, o, 7, lat, nd, nb, res, ni);
      checks++;
      if (lat !== exp_lat || nd !== 1 || res !== exp_res || nb !== exp_lat
          || ni !== ((o == 3'd5 || o == 3'd6) ? 1 : 0)) begin
        fails++;
        $display("FAIL random_op[%0d] op=%0d a=%0d b=%0d: got lat=%0d done=%0d res=%0d busy=%0d ill=%0d, want lat=%0d res=%0d",
                 i, o, a, b, lat, nd, res, nb, ni, exp_lat, exp_res);
      end
      prev_result = exp_res;
    end
  endtask

`ifdef ALU_RESP_OP_COUNT_EN
  task automatic test_op_count();
    int lat, nd, nb, ni;
    logic [15:0] res;
    checks++;
    if (op_count !== 16'(model_count)) begin
      fails++;
      $display("FAIL op_count_running: got %0d, want %0d", op_count, model_count);
    end
    test_reset();
    for (int i = 0; i < 5; i++) run_op(8'(i), 8'd2, 3'(i % 6), 6, lat, nd, nb, res, ni);
    checks++;
    if (op_count !== 16'd5) begin
      fails++;
      $display("FAIL op_count_five: got %0d, want 5", op_count);
    end
    test_reset();
    checks++;
    if (op_count !== 16'd0) begin
      fails++;
      $display("FAIL op_count_reset: got %0d, want 0", op_count);
    end
  endtask
`endif

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_mul_hold();
    test_single_ops();
    test_held_start();
    test_illegal();
    test_reset_mid_mul();
    test_random();
`ifdef ALU_RESP_OP_COUNT_EN
    test_op_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_op_responder.md
Name: alu_op_responder

Overview:
- Responder end of the ALU start/done operation handshake.
- Samples A/B/op when the initiator raises start, computes the result, returns it with a one-cycle done pulse.
- Sits behind the ALU operation interface as the execution engine for bench-driven or bus-driven initiators.
- Single-cycle ops complete in 1 cycle; multiply completes after a configurable latency.

Parameters:
- WIDTH, 8, operand width in bits; result is 2*WIDTH.
- MUL_LATENCY, 3, cycles from start-sample edge to done for mul_op; legal range 1..8.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- A  input  WIDTH  operand A, captured on start sample
- B  input  WIDTH  operand B, captured on start sample
- op  input  3  opcode: 0 no_op, 1 add_op, 2 and_op, 3 xor_op, 4 mul_op, 7 rst_op; 5/6 illegal
- start  input  1  request, held high by initiator until done observed
- done  output  1  one-cycle completion pulse, registered
- result  output  2*WIDTH  operation result, registered, held between completions
- illegal  output  1  one-cycle pulse coincident with done for opcodes 5/6
- busy  output  1  high from start-sample edge until the edge that asserts done

Behaviour:
- Reset (async, any state): state=IDLE, done=0, result=0, illegal=0, busy=0, mul counter=0, captured operands=0.
- States: IDLE, MUL_BUSY, DONE, WAIT_RELEASE.
- IDLE:
  - start sampled 1 at edge k: capture A, B, op.
  - op!=4: go to DONE, load result at edge k+1.
  - op=4: go to MUL_BUSY, busy=1.
- MUL_BUSY:
  - Counter counts MUL_LATENCY-1 cycles.
  - result loaded and DONE entered at edge k+MUL_LATENCY.
  - MUL_LATENCY=1 behaves like a single-cycle op.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next edge: start=0 -> IDLE; start=1 -> WAIT_RELEASE.
- WAIT_RELEASE: stay until start sampled 0, then IDLE. A held start never produces a second operation.
- Re-arm rule: a new operation requires start sampled 0 on at least one edge after done.
- Arithmetic, zero-extended to 2*WIDTH:
  - add = A+B, no overflow loss (255+255=510).
  - and = A&B.
  - xor = A^B.
  - mul = A*B, full product.
- no_op: done pulses, result holds its previous value.
- rst_op: result cleared to 0, done pulses.
- Illegal op (5/6): result=0, done and illegal pulse together.
- Operand/op changes after the sample edge are ignored until the next operation.
- start deasserted mid-multiply: operation still completes and done still pulses; DONE -> IDLE.
- Reset mid-operation: operation abandoned, no done pulse, result=0.

Optional Feature:
- Macro ALU_RESP_OP_COUNT_EN.
- Defined:
  - Adds output op_count [15:0], reset 0.
  - Increments on every done pulse (illegal ops included).
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Mul with hold: reset 2 cycles, A=3, B=5, op=4, start=1 held until done falls -> done pulses exactly at edge k+3, result=15, busy high edges k..k+2, illegal=0.
- Add full-scale: A=255, B=255, op=1 -> done at edge k+1, result=510; and_op A=8'hF0, B=8'h3C -> result=16'h0030; xor_op same operands -> 16'h00CC.
- Held start: op=1, start held 10 cycles -> exactly one done pulse; start low one cycle then high -> second done.
- Illegal op: op=5, A=9, B=9 -> done and illegal pulse together, result=0; next add_op 1+1 -> result=2, illegal=0.
- Reset mid-multiply: op=4, assert reset at edge k+1 -> done never pulses, result=0, busy=0; then op=7 after prior result 15 -> result=0, done pulses.
- Counter: with ALU_RESP_OP_COUNT_EN, 5 completed ops -> op_count=5; reset -> op_count=0.
